// File: rtl/mdr_alu_core.sv
// rtl/mdr_alu_core.sv - MDR, Y and Z registers around a combinational ALU
//
// Purpose: arithmetic core of the bus-based CPU datapath. MDR captures either
// memory data or the bus, Y holds the A operand, and the 64-bit Z register
// (Z_HI/Z_LO) captures the ALU result. All register contents are registered
// outputs returned to the bus mux.
//
// Ports:
//   clk       in   rising-edge clock
//   clr       in   synchronous active-high clear of MDR, Y, Z_HI, Z_LO
//   bus_in    in   shared datapath bus, also ALU operand B
//   mdata_in  in   memory read data
//   read      in   MDR source select (1 = mdata_in, 0 = bus_in)
//   mdr_in    in   MDR load enable
//   y_in      in   Y load enable (loads bus_in)
//   z_in      in   Z load enable (loads ALU {HI, LO})
//   opcode    in   ALU operation
//   inc_pc    in   forces result = bus_in + 1, HI = 0
//   brn_flag  in   branch-taken flag for the branch opcode
//   mdr_out   out  MDR contents
//   y_out     out  Y contents
//   z_hi_out  out  Z_HI contents
//   z_lo_out  out  Z_LO contents

module mdr_alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] mdata_in,
    input  logic             read,
    input  logic             mdr_in,
    input  logic             y_in,
    input  logic             z_in,
    input  logic [4:0]       opcode,
    input  logic             inc_pc,
    input  logic             brn_flag,
    output logic [WIDTH-1:0] mdr_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_hi_out,
    output logic [WIDTH-1:0] z_lo_out
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_LD     = 5'b00000;
    localparam logic [4:0] OP_LDI    = 5'b00001;
    localparam logic [4:0] OP_ST     = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_SHR    = 5'b00111;
    localparam logic [4:0] OP_SHRA   = 5'b01000;
    localparam logic [4:0] OP_SHL    = 5'b01001;
    localparam logic [4:0] OP_ROR    = 5'b01010;
    localparam logic [4:0] OP_ROL    = 5'b01011;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_ANDI   = 5'b01101;
    localparam logic [4:0] OP_ORI    = 5'b01110;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_NEG    = 5'b10001;
    localparam logic [4:0] OP_NOT    = 5'b10010;
    localparam logic [4:0] OP_BRANCH = 5'b10011;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z_hi;
    logic [WIDTH-1:0] r_z_lo;

    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_ror_full;
    logic [2*WIDTH-1:0] w_rol_full;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    // Only the low bits of B select the shift/rotate amount.
    assign w_sh = bus_in[SHW-1:0];

    // Rotates come from shifting a doubled copy of A: an amount of 0 returns A.
    assign w_dbl      = {r_y, r_y};
    assign w_ror_full = w_dbl >> w_sh;
    assign w_rol_full = w_dbl << w_sh;

    // Full-width signed product from sign-extended operands.
    assign w_prod = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y})
                  * $signed({{WIDTH{bus_in[WIDTH-1]}}, bus_in});

    // Divide by zero and the single overflowing case are resolved explicitly
    // so hardware and simulation agree on a defined result.
    always_comb begin
        w_quot = '0;
        w_rem  = r_y;
        if (bus_in == '0) begin
            w_quot = '0;
            w_rem  = r_y;
        end else if (r_y == MIN_NEG && bus_in == ALL_ONE) begin
            w_quot = MIN_NEG;
            w_rem  = '0;
        end else begin
            w_quot = $signed(r_y) / $signed(bus_in);
            w_rem  = $signed(r_y) % $signed(bus_in);
        end
    end

    always_comb begin
        w_hi = '0;
        w_lo = bus_in;
        if (inc_pc) begin
            w_lo = bus_in + ONE;
        end else begin
            case (opcode)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_lo = r_y + bus_in;
                OP_SUB:           w_lo = r_y - bus_in;
                OP_AND, OP_ANDI:  w_lo = r_y & bus_in;
                OP_OR, OP_ORI:    w_lo = r_y | bus_in;
                OP_SHR:           w_lo = r_y >> w_sh;
                OP_SHRA:          w_lo = $signed(r_y) >>> w_sh;
                OP_SHL:           w_lo = r_y << w_sh;
                OP_ROR:           w_lo = w_ror_full[WIDTH-1:0];
                OP_ROL:           w_lo = w_rol_full[2*WIDTH-1:WIDTH];
                OP_MUL: begin
                    w_hi = w_prod[2*WIDTH-1:WIDTH];
                    w_lo = w_prod[WIDTH-1:0];
                end
                OP_DIV: begin
                    w_hi = w_rem;
                    w_lo = w_quot;
                end
                OP_NEG:           w_lo = '0 - bus_in;
                OP_NOT:           w_lo = ~bus_in;
                OP_BRANCH:        w_lo = brn_flag ? (r_y + bus_in) : r_y;
                default:          w_lo = bus_in;
            endcase
        end
    end

    // Z samples the ALU before Y updates, so a same-cycle Y load is seen
    // only by the next evaluation.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_mdr  <= '0;
            r_y    <= '0;
            r_z_hi <= '0;
            r_z_lo <= '0;
        end else begin
            if (mdr_in) r_mdr <= read ? mdata_in : bus_in;
            if (y_in)   r_y   <= bus_in;
            if (z_in) begin
                r_z_hi <= w_hi;
                r_z_lo <= w_lo;
            end
        end
    end

    assign mdr_out  = r_mdr;
    assign y_out    = r_y;
    assign z_hi_out = r_z_hi;
    assign z_lo_out = r_z_lo;

endmodule

// File: tb/tb_mdr_alu_core.sv
// tb/tb_mdr_alu_core.sv - directed self-checking bench for mdr_alu_core

module tb_mdr_alu_core;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_in;
    logic [31:0] mdata_in;
    logic        read;
    logic        mdr_in;
    logic        y_in;
    logic        z_in;
    logic [4:0]  opcode;
    logic        inc_pc;
    logic        brn_flag;
    logic [31:0] mdr_out;
    logic [31:0] y_out;
    logic [31:0] z_hi_out;
    logic [31:0] z_lo_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdr_alu_core #(.WIDTH(32)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus_in   (bus_in),
        .mdata_in (mdata_in),
        .read     (read),
        .mdr_in   (mdr_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .opcode   (opcode),
        .inc_pc   (inc_pc),
        .brn_flag (brn_flag),
        .mdr_out  (mdr_out),
        .y_out    (y_out),
        .z_hi_out (z_hi_out),
        .z_lo_out (z_lo_out)
    );

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        clr = 0; mdr_in = 0; y_in = 0; z_in = 0; inc_pc = 0; brn_flag = 0;
        read = 0; opcode = 5'b00011;
    endtask

    task automatic load_y(input logic [31:0] v);
        idle();
        bus_in = v; y_in = 1;
        tick();
        y_in = 0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic inc, input logic brn);
        load_y(a);
        bus_in = b; opcode = op; inc_pc = inc; brn_flag = brn; z_in = 1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus_in = 0; mdata_in = 0;
        clr = 1;
        tick();
        clr = 0;
        check32("rst_mdr", mdr_out, 32'h0);
        check32("rst_y", y_out, 32'h0);
        check32("rst_zhi", z_hi_out, 32'h0);
        check32("rst_zlo", z_lo_out, 32'h0);

        // MDR source select and hold
        mdata_in = 32'hDEADBEEF; bus_in = 32'h12345678; read = 1; mdr_in = 1;
        tick();
        check32("mdr_mem", mdr_out, 32'hDEADBEEF);
        read = 0;
        tick();
        check32("mdr_bus", mdr_out, 32'h12345678);
        mdr_in = 0; bus_in = 32'h0BADF00D; read = 1;
        tick();
        check32("mdr_hold", mdr_out, 32'h12345678);
        idle();

        // Arithmetic and logic
        run_op(32'h22, 32'h7, 5'b00011, 0, 0);
        check32("add_lo", z_lo_out, 32'h29);
        check32("add_hi", z_hi_out, 32'h0);
        check32("y_loaded", y_out, 32'h22);
        run_op(32'h22, 32'h7, 5'b00100, 0, 0);
        check32("sub_lo", z_lo_out, 32'h1B);
        run_op(32'h22, 32'h7, 5'b00101, 0, 0);
        check32("and_lo", z_lo_out, 32'h2);
        run_op(32'h22, 32'h7, 5'b00110, 0, 0);
        check32("or_lo", z_lo_out, 32'h27);
        check32("or_hi", z_hi_out, 32'h0);
        run_op(32'h22, 32'h7, 5'b01100, 0, 0);
        check32("addi_lo", z_lo_out, 32'h29);
        run_op(32'hFFFFFFFF, 32'h2, 5'b00000, 0, 0);
        check32("ld_wrap", z_lo_out, 32'h1);

        // Shifts and rotates
        run_op(32'h80000001, 32'h4, 5'b00111, 0, 0);
        check32("shr", z_lo_out, 32'h08000000);
        run_op(32'h80000001, 32'h4, 5'b01000, 0, 0);
        check32("shra", z_lo_out, 32'hF8000000);
        run_op(32'h80000001, 32'h4, 5'b01001, 0, 0);
        check32("shl", z_lo_out, 32'h00000010);
        run_op(32'h80000001, 32'h4, 5'b01010, 0, 0);
        check32("ror", z_lo_out, 32'h18000000);
        run_op(32'h80000001, 32'h4, 5'b01011, 0, 0);
        check32("rol", z_lo_out, 32'h00000018);
        run_op(32'h80000001, 32'hFFFFFFE4, 5'b00111, 0, 0);
        check32("shr_upper_ignored", z_lo_out, 32'h08000000);
        run_op(32'h80000001, 32'h20, 5'b01010, 0, 0);
        check32("ror_zero", z_lo_out, 32'h80000001);
        run_op(32'h80000001, 32'h0, 5'b01000, 0, 0);
        check32("shra_zero", z_lo_out, 32'h80000001);

        // Multiply and divide
        run_op(32'hFFFFFFFA, 32'h7, 5'b01111, 0, 0);
        check32("mul_hi", z_hi_out, 32'hFFFFFFFF);
        check32("mul_lo", z_lo_out, 32'hFFFFFFD6);
        run_op(32'hFFFFFFF9, 32'h2, 5'b10000, 0, 0);
        check32("div_lo", z_lo_out, 32'hFFFFFFFD);
        check32("div_hi", z_hi_out, 32'hFFFFFFFF);
        run_op(32'h5, 32'h0, 5'b10000, 0, 0);
        check32("div0_lo", z_lo_out, 32'h0);
        check32("div0_hi", z_hi_out, 32'h5);

        // inc_pc overrides a div opcode and clears HI
        run_op(32'h5, 32'hFFFFFFFF, 5'b10000, 1, 0);
        check32("incpc_lo", z_lo_out, 32'h0);
        check32("incpc_hi", z_hi_out, 32'h0);

        // Misc
        run_op(32'h0, 32'h1, 5'b10001, 0, 0);
        check32("neg", z_lo_out, 32'hFFFFFFFF);
        run_op(32'h0, 32'h0F0F0F0F, 5'b10010, 0, 0);
        check32("not", z_lo_out, 32'hF0F0F0F0);
        run_op(32'h10, 32'h8, 5'b10011, 0, 1);
        check32("branch_taken", z_lo_out, 32'h18);
        run_op(32'h10, 32'h8, 5'b10011, 0, 0);
        check32("branch_not", z_lo_out, 32'h10);
        run_op(32'h10, 32'hABCD, 5'b10100, 0, 0);
        check32("pass", z_lo_out, 32'hABCD);

        // Y and Z in the same cycle: Z sees old Y (0x10)
        bus_in = 32'h5; opcode = 5'b00011; y_in = 1; z_in = 1;
        tick();
        idle();
        check32("same_cycle_z", z_lo_out, 32'h15);
        check32("same_cycle_y", y_out, 32'h5);

        // Clear with every enable high, then ALU runs with Y = 0
        mdata_in = 32'h1; read = 1; mdr_in = 1;
        tick();
        clr = 1; mdr_in = 1; y_in = 1; z_in = 1; bus_in = 32'h77; opcode = 5'b01111;
        tick();
        idle();
        check32("clr_mdr", mdr_out, 32'h0);
        check32("clr_y", y_out, 32'h0);
        check32("clr_zhi", z_hi_out, 32'h0);
        check32("clr_zlo", z_lo_out, 32'h0);
        bus_in = 32'h3; opcode = 5'b00011; z_in = 1;
        tick();
        idle();
        check32("post_clr_add", z_lo_out, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
